// File: rtl/output_accum_ctrl.sv
// Read-modify-write accumulation scheduler for the output memory: round-robin grant + read (A), write (B).
// Optional build macro OUTMEM_SAT_EN: saturating lane adds with a sticky sat_flag; otherwise lanes wrap.
module output_accum_ctrl #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned LANES  = 16,
  parameter int unsigned LANE_W = 32,
  localparam int unsigned DATA_W = LANES * LANE_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req0_first,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  input  logic              req1_first,
  input  logic [1:0]        scan_mode,
  output logic              mem_rd_valid,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              mem_wr_valid,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  output logic              busy,
  output logic [15:0]       wr_count,
  output logic              sat_flag
);

  logic              halt;
  logic              grant0;
  logic              grant1;
  logic              grant;
  logic              rr_ptr;   // 1: req1 has priority on a tie
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_data;
  logic              a_first;
  logic              fwd_hit;
  logic [DATA_W-1:0] operand;
  logic [DATA_W-1:0] sum;
  logic [LANE_W-1:0] lane_a;
  logic [LANE_W-1:0] lane_o;

  assign halt = (scan_mode == 2'd0) || (scan_mode == 2'd3);

  // Round-robin arbitration; nothing is granted in reset or during a scan mode
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (reset && !halt) begin
      grant0 = req0_valid && (!req1_valid || !rr_ptr);
      grant1 = req1_valid && (!req0_valid ||  rr_ptr);
    end
  end

  assign grant      = grant0 | grant1;
  assign req0_ready = grant0;
  assign req1_ready = grant1;

  assign a_addr  = grant1 ? req1_addr  : req0_addr;
  assign a_data  = grant1 ? req1_data  : req0_data;
  assign a_first = grant1 ? req1_first : req0_first;

  assign mem_rd_valid = grant && !a_first;
  assign mem_rd_addr  = grant ? a_addr : '0;

  // Stage B still holds the previous sum for the same word: the memory copy is stale
  assign fwd_hit = mem_wr_valid && (mem_wr_addr == a_addr);
  assign operand = a_first ? '0 : (fwd_hit ? mem_wr_data : mem_rd_data);

  assign busy = mem_wr_valid | req0_valid | req1_valid;

`ifdef OUTMEM_SAT_EN
  logic [LANE_W:0] wide;
  logic            sat_any;

  always_comb begin
    sum     = '0;
    sat_any = 1'b0;
    wide    = '0;
    lane_a  = '0;
    lane_o  = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      lane_a = a_data[i*LANE_W +: LANE_W];
      lane_o = operand[i*LANE_W +: LANE_W];
      wide   = {lane_a[LANE_W-1], lane_a} + {lane_o[LANE_W-1], lane_o};
      // Top two bits disagree only on signed overflow; the top bit gives the direction
      if (wide[LANE_W] != wide[LANE_W-1]) begin
        sat_any = 1'b1;
        sum[i*LANE_W +: LANE_W] = wide[LANE_W] ? {1'b1, {(LANE_W-1){1'b0}}}
                                               : {1'b0, {(LANE_W-1){1'b1}}};
      end else begin
        sum[i*LANE_W +: LANE_W] = wide[LANE_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sat_flag <= 1'b0;
    end else if (grant && sat_any) begin
      sat_flag <= 1'b1;
    end
  end
`else
  always_comb begin
    sum    = '0;
    lane_a = '0;
    lane_o = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      lane_a = a_data[i*LANE_W +: LANE_W];
      lane_o = operand[i*LANE_W +: LANE_W];
      sum[i*LANE_W +: LANE_W] = lane_a + lane_o;
    end
  end

  assign sat_flag = 1'b0;
`endif

  // Stage B / write port, round-robin pointer and write counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr       <= 1'b0;
      mem_wr_valid <= 1'b0;
      mem_wr_addr  <= '0;
      mem_wr_data  <= '0;
      wr_count     <= 16'd0;
    end else begin
      mem_wr_valid <= grant;
      if (grant) begin
        rr_ptr      <= grant0;
        mem_wr_addr <= a_addr;
        mem_wr_data <= sum;
      end
      if (mem_wr_valid) begin
        wr_count <= wr_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_output_accum_ctrl.sv
// Scoreboard bench for output_accum_ctrl: predicts grants and lane sums, checks the write port.
module tb_output_accum_ctrl;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned LANES  = 16;
  localparam int unsigned LANE_W = 32;
  localparam int unsigned DATA_W = LANES * LANE_W;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              req0_valid, req1_valid;
  logic              req0_ready, req1_ready;
  logic [ADDR_W-1:0] req0_addr, req1_addr;
  logic [DATA_W-1:0] req0_data, req1_data;
  logic              req0_first, req1_first;
  logic [1:0]        scan_mode;
  logic              mem_rd_valid;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [DATA_W-1:0] mem_rd_data;
  logic              mem_wr_valid;
  logic [ADDR_W-1:0] mem_wr_addr;
  logic [DATA_W-1:0] mem_wr_data;
  logic              busy;
  logic [15:0]       wr_count;
  logic              sat_flag;

  logic [DATA_W-1:0] tb_mem  [DEPTH];
  logic [DATA_W-1:0] ref_mem [DEPTH];
  wr_t               sb_q [$];

  int unsigned       n_checks = 0;
  int unsigned       n_fail   = 0;
  logic              wr_pend  = 1'b0;
  logic              m_ptr    = 1'b0;
  logic [15:0]       exp_count = 16'd0;
  logic              exp_sat  = 1'b0;
  logic [DATA_W-1:0] last_wr_data = '0;

  output_accum_ctrl #(.ADDR_W(ADDR_W), .LANES(LANES), .LANE_W(LANE_W)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr),
    .req0_data(req0_data), .req0_first(req0_first),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr),
    .req1_data(req1_data), .req1_first(req1_first),
    .scan_mode(scan_mode),
    .mem_rd_valid(mem_rd_valid), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .mem_wr_valid(mem_wr_valid), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .busy(busy), .wr_count(wr_count), .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  // Output memory: read data in the address cycle, write lands at the edge
  assign mem_rd_data = tb_mem[mem_rd_addr];
  always @(posedge clk) begin
    if (mem_wr_valid) tb_mem[mem_wr_addr] <= mem_wr_data;
  end

  function automatic logic [DATA_W-1:0] rand_data();
    logic [DATA_W-1:0] r;
    r = '0;
    for (int i = 0; i < int'(LANES); i++) r[i*LANE_W +: LANE_W] = LANE_W'($urandom());
    return r;
  endfunction

  function automatic void lane_add(input logic [DATA_W-1:0] x, input logic [DATA_W-1:0] y,
                                   output logic [DATA_W-1:0] r, output logic s);
    longint sx, sy, t;
    longint maxv, minv;
    maxv = (64'sd1 <<< (LANE_W - 1)) - 64'sd1;
    minv = -(64'sd1 <<< (LANE_W - 1));
    r = '0;
    s = 1'b0;
    for (int i = 0; i < int'(LANES); i++) begin
      sx = longint'($signed(x[i*LANE_W +: LANE_W]));
      sy = longint'($signed(y[i*LANE_W +: LANE_W]));
      t  = sx + sy;
`ifdef OUTMEM_SAT_EN
      if (t > maxv) begin t = maxv; s = 1'b1; end
      else if (t < minv) begin t = minv; s = 1'b1; end
`endif
      r[i*LANE_W +: LANE_W] = LANE_W'(t);
    end
  endfunction

  // One clock: check write port and comb outputs, predict this cycle's grant
  task automatic cycle(output logic g0, output logic g1);
    logic              eg0, eg1, halt_m, f, s, new_pend;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d, op, e;
    wr_t               w;
    s = 1'b0;
    @(negedge clk);
    n_checks++;
    if (mem_wr_valid !== wr_pend) begin
      n_fail++;
      $display("FAIL wr_valid: got %b want %b at %0t", mem_wr_valid, wr_pend, $time);
    end else if (wr_pend) begin
      w = sb_q.pop_front();
      last_wr_data = mem_wr_data;
      n_checks++;
      if (mem_wr_addr !== w.addr) begin
        n_fail++;
        $display("FAIL wr_addr: got %0d want %0d", mem_wr_addr, w.addr);
      end
      n_checks++;
      if (mem_wr_data !== w.data) begin
        n_fail++;
        $display("FAIL wr_data addr %0d: got %h want %h", w.addr, mem_wr_data, w.data);
      end
    end
    n_checks++;
    if (wr_count !== exp_count) begin
      n_fail++;
      $display("FAIL wr_count: got %0d want %0d", wr_count, exp_count);
    end
    n_checks++;
    if (sat_flag !== exp_sat) begin
      n_fail++;
      $display("FAIL sat_flag: got %b want %b", sat_flag, exp_sat);
    end
    n_checks++;
    if (busy !== (wr_pend | req0_valid | req1_valid)) begin
      n_fail++;
      $display("FAIL busy: got %b want %b", busy, wr_pend | req0_valid | req1_valid);
    end
    halt_m = (scan_mode == 2'd0) || (scan_mode == 2'd3);
    eg0 = !halt_m && req0_valid && (!req1_valid || !m_ptr);
    eg1 = !halt_m && req1_valid && (!req0_valid ||  m_ptr);
    new_pend = eg0 | eg1;
    a = eg1 ? req1_addr  : req0_addr;
    d = eg1 ? req1_data  : req0_data;
    f = eg1 ? req1_first : req0_first;
    n_checks++;
    if ({req0_ready, req1_ready} !== {eg0, eg1}) begin
      n_fail++;
      $display("FAIL ready: got %b%b want %b%b", req0_ready, req1_ready, eg0, eg1);
    end
    n_checks++;
    if (mem_rd_valid !== (new_pend && !f)) begin
      n_fail++;
      $display("FAIL rd_valid: got %b want %b", mem_rd_valid, new_pend && !f);
    end
    n_checks++;
    if (mem_rd_addr !== (new_pend ? a : ADDR_W'(0))) begin
      n_fail++;
      $display("FAIL rd_addr: got %0d want %0d", mem_rd_addr, new_pend ? a : ADDR_W'(0));
    end
    g0 = req0_ready;
    g1 = req1_ready;
    if (new_pend) begin
      op = f ? '0 : ref_mem[a];
      lane_add(d, op, e, s);
      ref_mem[a] = e;
      w.addr = a;
      w.data = e;
      sb_q.push_back(w);
      m_ptr = eg0;
    end
    @(posedge clk);
    if (wr_pend) exp_count = exp_count + 16'd1;
    wr_pend = new_pend;
    exp_sat = exp_sat | s;
    #1;
  endtask

  task automatic idle(input int n);
    logic g0, g1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    for (int i = 0; i < n; i++) cycle(g0, g1);
  endtask

  task automatic test_reset();
    logic g0, g1;
    reset = 1'b0;
    scan_mode = 2'd1;
    req0_valid = 1'b1; req0_addr = 8'd1; req0_data = rand_data(); req0_first = 1'b1;
    req1_valid = 1'b1; req1_addr = 8'd2; req1_data = rand_data(); req1_first = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({req0_ready, req1_ready, mem_rd_valid, mem_wr_valid} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b want 0000",
               {req0_ready, req1_ready, mem_rd_valid, mem_wr_valid});
    end
    n_checks++;
    if (wr_count !== 16'd0 || sat_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_regs: got count %0d sat %b want 0 0", wr_count, sat_flag);
    end
    @(posedge clk);
    #1 reset = 1'b1;
    cycle(g0, g1);
    n_checks++;
    if ({g0, g1} !== 2'b10) begin
      n_fail++;
      $display("FAIL first_grant: got %b%b want 10", g0, g1);
    end
  endtask

  task automatic test_forward();
    logic g0, g1;
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_addr = 8'd5; req0_first = 1'b1; req0_data = {LANES{32'd7}};
    cycle(g0, g1);
    req0_first = 1'b0; req0_data = {LANES{32'd3}};
    cycle(g0, g1);
    idle(1);
    n_checks++;
    if (last_wr_data !== {LANES{32'd10}}) begin
      n_fail++;
      $display("FAIL forward_sum: got %h want all lanes 10", last_wr_data);
    end
    idle(1);
    n_checks++;
    if (wr_count !== 16'd3) begin
      n_fail++;
      $display("FAIL forward_count: got %0d want 3", wr_count);
    end
  endtask

  task automatic test_round_robin();
    logic g0, g1;
    req1_valid = 1'b1; req1_addr = 8'd51; req1_first = 1'b1; req1_data = rand_data();
    cycle(g0, g1);
    req1_first = 1'b0;
    req0_valid = 1'b1; req0_addr = 8'd50;
    for (int i = 0; i < 6; i++) begin
      req0_first = (i == 0);
      req0_data  = rand_data();
      req1_data  = rand_data();
      cycle(g0, g1);
      n_checks++;
      if ({g0, g1} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
        n_fail++;
        $display("FAIL rr_grant[%0d]: got %b%b want %s", i, g0, g1, (i % 2 == 0) ? "10" : "01");
      end
    end
    idle(1);
  endtask

  task automatic test_read_accum();
    logic g0, g1;
    logic [DATA_W-1:0] v;
    v = '0;
    v[LANE_W-1:0] = 32'd100;
    tb_mem[9]  = v;
    ref_mem[9] = v;
    v[LANE_W-1:0] = -32'sd30;
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_addr = 8'd9; req0_first = 1'b0; req0_data = v;
    cycle(g0, g1);
    idle(1);
    n_checks++;
    if (last_wr_data[LANE_W-1:0] !== 32'd70) begin
      n_fail++;
      $display("FAIL read_accum: got %0d want 70", $signed(last_wr_data[LANE_W-1:0]));
    end
  endtask

  task automatic test_halt();
    logic g0, g1;
    req0_valid = 1'b1; req0_addr = 8'd60; req0_first = 1'b1; req0_data = rand_data();
    cycle(g0, g1);
    scan_mode = 2'd3;
    cycle(g0, g1);
    n_checks++;
    if (g0 !== 1'b0) begin
      n_fail++;
      $display("FAIL halt_scan_out: got ready %b want 0", g0);
    end
    scan_mode = 2'd0;
    cycle(g0, g1);
    n_checks++;
    if (g0 !== 1'b0) begin
      n_fail++;
      $display("FAIL halt_scan_in: got ready %b want 0", g0);
    end
    scan_mode = 2'd1;
    req0_first = 1'b0;
    cycle(g0, g1);
    n_checks++;
    if (g0 !== 1'b1) begin
      n_fail++;
      $display("FAIL halt_resume: got ready %b want 1", g0);
    end
    scan_mode = 2'd2;
    idle(1);
  endtask

  task automatic test_boundary();
    logic g0, g1;
    req1_valid = 1'b0;
    req0_valid = 1'b1;
    req0_addr = 8'd0;   req0_first = 1'b1; req0_data = rand_data(); cycle(g0, g1);
    req0_addr = 8'd255; req0_first = 1'b1; req0_data = rand_data(); cycle(g0, g1);
    req0_addr = 8'd255; req0_first = 1'b0; req0_data = rand_data(); cycle(g0, g1);
    req0_addr = 8'd255; req0_first = 1'b1; req0_data = rand_data(); cycle(g0, g1);
    req0_addr = 8'd0;   req0_first = 1'b0; req0_data = rand_data(); cycle(g0, g1);
    idle(1);
  endtask

  task automatic test_saturation();
    logic g0, g1;
    logic [DATA_W-1:0] v;
    v = '0;
    v[LANE_W-1:0] = 32'h7FFF_FFFF;
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_addr = 8'd20; req0_first = 1'b1; req0_data = v;
    cycle(g0, g1);
    v[LANE_W-1:0] = 32'h0000_0001;
    req0_first = 1'b0; req0_data = v;
    cycle(g0, g1);
    idle(1);
`ifdef OUTMEM_SAT_EN
    n_checks++;
    if (last_wr_data[LANE_W-1:0] !== 32'h7FFF_FFFF || sat_flag !== 1'b1) begin
      n_fail++;
      $display("FAIL saturate: got %h sat %b want 7fffffff sat 1", last_wr_data[LANE_W-1:0], sat_flag);
    end
`else
    n_checks++;
    if (last_wr_data[LANE_W-1:0] !== 32'h8000_0000 || sat_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap: got %h sat %b want 80000000 sat 0", last_wr_data[LANE_W-1:0], sat_flag);
    end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      tb_mem[i]  = '0;
      ref_mem[i] = '0;
    end
    test_reset();
    test_forward();
    test_round_robin();
    test_read_accum();
    test_halt();
    test_boundary();
    test_saturation();
    idle(2);
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending writes want 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
